// File: rtl/captura_jogada.sv
// Debounced single-button play capture with multi-press detection.
// Optional inactivity timeout is compiled in with macro CAPTURA_TIMEOUT_EN.
module captura_jogada #(
   parameter int DEBOUNCE_CICLOS = 1000,
   parameter int TIMEOUT_CICLOS  = 50000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] botoes,
   input  logic       habilita,
   output logic [1:0] jogada,
   output logic       jogada_valida,
   output logic       erro_multiplo,
   output logic       timeout,
   output logic       ocupado
);

   localparam int DEB_W = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
   localparam logic [DEB_W-1:0] DEB_FIM = DEB_W'(DEBOUNCE_CICLOS - 1);

   localparam logic [1:0] ESPERA      = 2'd0;
   localparam logic [1:0] FILTRO      = 2'd1;
   localparam logic [1:0] PRESSIONADO = 2'd2;
   localparam logic [1:0] SOLTURA     = 2'd3;

   logic [3:0]       sync_a, sync_b;
   logic [1:0]       estado, prox_estado;
   logic [DEB_W-1:0] cnt_deb, prox_cnt_deb;
   logic [1:0]       indice, prox_indice;
   logic [1:0]       codigo;
   logic [3:0]       padrao;
   logic             um_bit, algum_bit, varios_bits;
   logic             aceita, multiplo;

   assign um_bit      = $onehot(sync_b);
   assign algum_bit   = |sync_b;
   assign varios_bits = algum_bit && !um_bit;
   assign padrao      = 4'b0001 << indice;

   always_comb begin
      codigo = 2'd0;
      case (sync_b)
         4'b0001: codigo = 2'd0;
         4'b0010: codigo = 2'd1;
         4'b0100: codigo = 2'd2;
         4'b1000: codigo = 2'd3;
         default: codigo = 2'd0;
      endcase
   end

   // The debounce counter is shared: it filters the press in FILTRO and the release in SOLTURA.
   always_comb begin
      prox_estado  = estado;
      prox_cnt_deb = cnt_deb;
      prox_indice  = indice;
      aceita       = 1'b0;
      multiplo     = 1'b0;
      case (estado)
         ESPERA: begin
            if (habilita) begin
               if (um_bit) begin
                  prox_estado  = FILTRO;
                  prox_indice  = codigo;
                  prox_cnt_deb = '0;
               end else if (varios_bits) begin
                  prox_estado = PRESSIONADO;
                  multiplo    = 1'b1;
               end
            end
         end
         FILTRO: begin
            if (!habilita || (sync_b != padrao)) begin
               prox_estado = ESPERA;
            end else if (cnt_deb == DEB_FIM) begin
               prox_estado = PRESSIONADO;
               aceita      = 1'b1;
            end else begin
               prox_cnt_deb = cnt_deb + 1'b1;
            end
         end
         PRESSIONADO: begin
            if (!algum_bit) begin
               prox_estado  = SOLTURA;
               prox_cnt_deb = '0;
            end
         end
         SOLTURA: begin
            if (algum_bit) begin
               prox_cnt_deb = '0;
            end else if (cnt_deb == DEB_FIM) begin
               prox_estado = ESPERA;
            end else begin
               prox_cnt_deb = cnt_deb + 1'b1;
            end
         end
         default: prox_estado = ESPERA;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_a        <= '0;
         sync_b        <= '0;
         estado        <= ESPERA;
         cnt_deb       <= '0;
         indice        <= '0;
         jogada        <= '0;
         jogada_valida <= 1'b0;
         erro_multiplo <= 1'b0;
         ocupado       <= 1'b0;
      end else begin
         sync_a        <= botoes;
         sync_b        <= sync_a;
         estado        <= prox_estado;
         cnt_deb       <= prox_cnt_deb;
         indice        <= prox_indice;
         jogada_valida <= aceita;
         erro_multiplo <= multiplo;
         ocupado       <= (prox_estado != ESPERA);
         if (aceita) begin
            jogada <= indice;
         end
      end
   end

`ifdef CAPTURA_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
   localparam logic [TMO_W-1:0] TMO_FIM = TMO_W'(TIMEOUT_CICLOS - 1);

   logic [TMO_W-1:0] cnt_tmo;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_tmo <= '0;
         timeout <= 1'b0;
      end else if (!habilita || aceita || multiplo) begin
         cnt_tmo <= '0;
         timeout <= 1'b0;
      end else if (cnt_tmo == TMO_FIM) begin
         cnt_tmo <= '0;
         timeout <= 1'b1;
      end else begin
         cnt_tmo <= cnt_tmo + 1'b1;
         timeout <= 1'b0;
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_captura_jogada.sv
// Self-checking bench for captura_jogada: vector table, directed corner sequences
// and randomized stimulus against a behavioural model of the capture rules.
module tb_captura_jogada;

   localparam int D = 4;
   localparam int T = 20;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] botoes = '0;
   logic       habilita = 1'b0;
   logic [1:0] jogada;
   logic       jogada_valida, erro_multiplo, timeout, ocupado;

   captura_jogada #(.DEBOUNCE_CICLOS(D), .TIMEOUT_CICLOS(T)) dut (
      .clock(clock), .reset(reset), .botoes(botoes), .habilita(habilita),
      .jogada(jogada), .jogada_valida(jogada_valida), .erro_multiplo(erro_multiplo),
      .timeout(timeout), .ocupado(ocupado)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;
   int ciclo = 0;
   int cnt_v = 0, cnt_e = 0, cnt_t = 0;

   // Behavioural model: raw samples delayed two edges, then the press/release rules.
   logic [3:0] h0, h1, alvo;
   bit         ocup_m, preso_m, soltou_m;
   int         run_m, quieto_m, tcount_m;
   logic [1:0] m_jogada;
   bit         m_valid, m_erro, m_tmo;

   function automatic void modelo_reset();
      h0 = '0; h1 = '0; alvo = '0;
      ocup_m = 0; preso_m = 0; soltou_m = 0;
      run_m = 0; quieto_m = 0; tcount_m = 0;
      m_jogada = '0; m_valid = 0; m_erro = 0; m_tmo = 0;
   endfunction

   function automatic void modelo_borda();
      logic [3:0] s;
      s  = h1;
      h1 = h0;
      h0 = botoes;
      m_valid = 0;
      m_erro  = 0;
      if (!ocup_m) begin
         if (habilita && $countones(s) == 1) begin
            ocup_m = 1; preso_m = 0; alvo = s; run_m = 1;
         end else if (habilita && $countones(s) > 1) begin
            ocup_m = 1; preso_m = 1; soltou_m = 0; m_erro = 1;
         end
      end else if (!preso_m) begin
         if (!habilita || s != alvo) begin
            ocup_m = 0;
         end else begin
            run_m++;
            if (run_m == D + 1) begin
               preso_m = 1; soltou_m = 0; m_valid = 1;
               for (int b = 0; b < 4; b++) if (alvo[b]) m_jogada = 2'(b);
            end
         end
      end else if (!soltou_m) begin
         if (s == 0) begin
            soltou_m = 1; quieto_m = 0;
         end
      end else begin
         if (s != 0) quieto_m = 0;
         else begin
            quieto_m++;
            if (quieto_m == D) ocup_m = 0;
         end
      end
`ifdef CAPTURA_TIMEOUT_EN
      if (!habilita || m_valid || m_erro) begin
         tcount_m = 0; m_tmo = 0;
      end else begin
         tcount_m++;
         m_tmo = (tcount_m == T);
         if (m_tmo) tcount_m = 0;
      end
`else
      m_tmo = 0;
`endif
   endfunction

   task automatic comparar(input string nome, input int atual, input int esperado);
      n_cmp++;
      if (atual != esperado) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
      end
   endtask

   task automatic comparar_saidas();
      logic [5:0] atual, esperado;
      atual    = {jogada, jogada_valida, erro_multiplo, timeout, ocupado};
      esperado = {m_jogada, m_valid, m_erro, m_tmo, ocup_m};
      n_cmp++;
      if (atual != esperado) begin
         n_err++;
         $display("FAIL saidas ciclo %0d: got %b expected %b (jogada,valida,erro,timeout,ocupado)",
                  ciclo, atual, esperado);
      end
   endtask

   task automatic step();
      @(posedge clock);
      modelo_borda();
      #1;
      ciclo++;
      comparar_saidas();
      if (jogada_valida) cnt_v++;
      if (erro_multiplo) cnt_e++;
      if (timeout)       cnt_t++;
   endtask

   typedef struct {
      logic       hab;
      logic [3:0] pat;
      int         hold;
      int         exp_v;
      int         exp_e;
      logic [1:0] exp_j;
   } vetor_t;

   vetor_t tab[9];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int v_ciclo, subida, queda, e_ciclo, t1, t2, dur, r;
      logic oc_visto;

      tab[0] = '{1'b1, 4'b0001,  8, 1, 0, 2'b00};
      tab[1] = '{1'b1, 4'b0010,  8, 1, 0, 2'b01};
      tab[2] = '{1'b1, 4'b1000,  8, 1, 0, 2'b11};
      tab[3] = '{1'b1, 4'b0100,  5, 1, 0, 2'b10};
      tab[4] = '{1'b1, 4'b0001,  4, 0, 0, 2'b10};
      tab[5] = '{1'b1, 4'b0011,  6, 0, 1, 2'b10};
      tab[6] = '{1'b0, 4'b0100, 10, 0, 0, 2'b10};
      tab[7] = '{1'b1, 4'b1111,  3, 0, 1, 2'b10};
      tab[8] = '{1'b1, 4'b1000, 30, 1, 0, 2'b11};

      modelo_reset();
      #2;
      comparar("reset_inicial", int'({jogada, jogada_valida, erro_multiplo, timeout, ocupado}), 0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (3) step();

      for (int i = 0; i < 9; i++) begin
         habilita = 1'b0; botoes = '0;
         repeat (2) step();
         cnt_v = 0; cnt_e = 0;
         habilita = tab[i].hab; botoes = tab[i].pat;
         repeat (tab[i].hold) step();
         botoes = '0;
         repeat (12) step();
         comparar($sformatf("tab%0d_valida", i), cnt_v, tab[i].exp_v);
         comparar($sformatf("tab%0d_erro", i), cnt_e, tab[i].exp_e);
         comparar($sformatf("tab%0d_jogada", i), int'(jogada), int'(tab[i].exp_j));
         comparar($sformatf("tab%0d_ocupado", i), int'(ocupado), 0);
      end

      // Clean press of button 2, held 10 cycles
      habilita = 1'b0; botoes = '0; repeat (3) step();
      habilita = 1'b1; botoes = 4'b0100;
      cnt_v = 0; v_ciclo = -1; subida = -1; queda = -1;
      for (int k = 1; k <= 22; k++) begin
         if (k == 11) botoes = '0;
         step();
         if (jogada_valida && v_ciclo < 0) v_ciclo = k;
         if (ocupado && subida < 0) subida = k;
         if (!ocupado && subida >= 0 && queda < 0) queda = k;
      end
      comparar("limpo_ciclo_valida", v_ciclo, 7);
      comparar("limpo_n_valida", cnt_v, 1);
      comparar("limpo_jogada", int'(jogada), 2);
      comparar("limpo_ocupado_sobe", subida, 3);
      comparar("limpo_ocupado_desce", queda, 17);

      // Bounce on button 0, then stable
      habilita = 1'b0; botoes = '0; repeat (3) step();
      habilita = 1'b1; cnt_v = 0; v_ciclo = -1;
      for (int k = 1; k <= 24; k++) begin
         botoes = (k <= 12 && ((k - 1) % 4) >= 2) ? 4'b0000 : 4'b0001;
         step();
         if (jogada_valida && v_ciclo < 0) v_ciclo = k;
      end
      comparar("bounce_ciclo_valida", v_ciclo, 19);
      comparar("bounce_n_valida", cnt_v, 1);
      comparar("bounce_jogada", int'(jogada), 0);
      botoes = '0; habilita = 1'b0; repeat (10) step();

      // Two buttons pressed together
      habilita = 1'b1; botoes = 4'b1010;
      cnt_v = 0; cnt_e = 0; e_ciclo = -1; queda = -1;
      for (int k = 1; k <= 20; k++) begin
         if (k == 9) botoes = '0;
         step();
         if (erro_multiplo && e_ciclo < 0) e_ciclo = k;
         if (!ocupado && e_ciclo >= 0 && queda < 0) queda = k;
      end
      comparar("multi_ciclo_erro", e_ciclo, 3);
      comparar("multi_n_erro", cnt_e, 1);
      comparar("multi_n_valida", cnt_v, 0);
      comparar("multi_jogada", int'(jogada), 0);
      comparar("multi_ocupado_desce", queda, 15);

      // Capture disabled
      habilita = 1'b0; botoes = 4'b1000;
      cnt_v = 0; cnt_e = 0; cnt_t = 0; oc_visto = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (ocupado) oc_visto = 1'b1;
      end
      comparar("desab_pulsos", cnt_v + cnt_e + cnt_t, 0);
      comparar("desab_ocupado", int'(oc_visto), 0);
      botoes = '0; repeat (3) step();

      // Inactivity timeout
      habilita = 1'b1; cnt_t = 0; t1 = -1; t2 = -1;
      for (int k = 1; k <= 45; k++) begin
         step();
         if (timeout) begin
            if (t1 < 0) t1 = k;
            else if (t2 < 0) t2 = k;
         end
      end
`ifdef CAPTURA_TIMEOUT_EN
      comparar("timeout_n", cnt_t, 2);
      comparar("timeout_primeiro", t1, 20);
      comparar("timeout_segundo", t2, 40);
`else
      comparar("timeout_n", cnt_t, 0);
`endif

      // Reset asserted two cycles into the debounce window
      habilita = 1'b0; botoes = '0; repeat (3) step();
      habilita = 1'b1; botoes = 4'b0010;
      repeat (5) step();
      comparar("reset_meio_ocupado_antes", int'(ocupado), 1);
      reset = 1'b0;
      modelo_reset();
      #1;
      comparar("reset_meio_assincrono", int'({jogada, jogada_valida, erro_multiplo, timeout, ocupado}), 0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      comparar("reset_meio_mantido", int'({jogada, jogada_valida, erro_multiplo, timeout, ocupado}), 0);
      reset = 1'b1;
      cnt_v = 0; v_ciclo = -1;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (jogada_valida && v_ciclo < 0) v_ciclo = k;
      end
      comparar("reset_meio_ciclo_valida", v_ciclo, 7);
      comparar("reset_meio_n_valida", cnt_v, 1);
      comparar("reset_meio_jogada", int'(jogada), 1);
      botoes = '0; habilita = 1'b0; repeat (10) step();

      // Randomized stimulus checked cycle by cycle against the model
      habilita = 1'b1; dur = 0;
      for (int i = 0; i < 3000; i++) begin
         if (dur == 0) begin
            r = $urandom_range(0, 9);
            if (r < 4)      botoes = '0;
            else if (r < 8) botoes = 4'(1 << $urandom_range(0, 3));
            else            botoes = 4'($urandom_range(0, 15));
            dur = $urandom_range(1, 9);
            if ($urandom_range(0, 15) == 0) habilita = ~habilita;
         end
         dur--;
         if ($urandom_range(0, 599) == 0) begin
            reset = 1'b0;
            modelo_reset();
            @(posedge clock); #1;
            reset = 1'b1;
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
